// File: rtl/ref_pingpong_bank.sv
// Double-buffered reference-pixel bank: the loader fills one half while the
// PE array reads the other; halves swap through a full/release handshake.
module ref_pingpong_bank #(
    parameter int unsigned PIXEL        = 8,
    parameter int unsigned PIX_PER_WORD = 8,
    parameter int unsigned DEPTH        = 96,
    parameter int unsigned AW           = 7
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    input  logic [PIX_PER_WORD*PIXEL-1:0] wr_data,
    output logic                          wr_ready,
    output logic                          wr_half,
    input  logic                          rd_en,
    input  logic [AW-1:0]                 rd_addr,
    input  logic                          rd_done,
    output logic                          rd_bank_valid,
    output logic                          rd_half,
    output logic [PIX_PER_WORD*PIXEL-1:0] rd_data,
    output logic                          rd_data_valid,
    output logic                          rd_err
);

    localparam int unsigned    W       = PIX_PER_WORD * PIXEL;
    localparam logic [AW-1:0]  CntLast = AW'(DEPTH - 1);
    localparam logic [AW:0]    DepthW  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {StEmpty, StFill, StFull} half_state_e;

    half_state_e   state_q [2];
    logic          wr_half_q;
    logic          rd_half_q;
    logic [AW-1:0] wr_cnt_q;
    logic [W-1:0]  rd_data_q;
    logic          rd_data_valid_q;
    logic          rd_err_q;
    logic [W-1:0]  mem [2][DEPTH];

    logic wr_accept;
    logic wr_last;
    logic rd_ok;
    logic rd_release;

    assign wr_ready      = (state_q[wr_half_q] != StFull);
    assign rd_bank_valid = (state_q[rd_half_q] == StFull);
    assign wr_half       = wr_half_q;
    assign rd_half       = rd_half_q;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_data_valid_q;
    assign rd_err        = rd_err_q;

    assign wr_accept  = wr_valid & wr_ready;
    assign wr_last    = (wr_cnt_q == CntLast);
    assign rd_ok      = rd_en & rd_bank_valid & ({1'b0, rd_addr} < DepthW);
    assign rd_release = rd_done & rd_bank_valid;

    // Storage has no reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (rst_n && wr_accept) begin
            mem[wr_half_q][wr_cnt_q] <= wr_data;
        end
    end

    // Write and release always hit different halves: a release needs a FULL
    // half, an accept needs a non-FULL one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q[0]      <= StEmpty;
            state_q[1]      <= StEmpty;
            wr_half_q       <= 1'b0;
            rd_half_q       <= 1'b0;
            wr_cnt_q        <= '0;
            rd_data_q       <= '0;
            rd_data_valid_q <= 1'b0;
            rd_err_q        <= 1'b0;
        end else begin
            if (wr_accept) begin
                state_q[wr_half_q] <= wr_last ? StFull : StFill;
                wr_cnt_q           <= wr_last ? '0 : wr_cnt_q + 1'b1;
                if (wr_last) begin
                    wr_half_q <= ~wr_half_q;
                end
            end
            if (rd_release) begin
                state_q[rd_half_q] <= StEmpty;
                rd_half_q          <= ~rd_half_q;
            end
            rd_data_valid_q <= rd_ok;
            rd_err_q        <= rd_en & ~rd_ok;
            if (rd_ok) begin
                rd_data_q <= mem[rd_half_q][rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_ref_pingpong_bank.sv
// Randomized bench for ref_pingpong_bank against a band-queue reference model.
module tb_ref_pingpong_bank;

    localparam int unsigned PIXEL = 8;
    localparam int unsigned PPW   = 8;
    localparam int unsigned DEPTH = 96;
    localparam int unsigned AW    = 7;
    localparam int unsigned W     = PIXEL * PPW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          wr_ready;
    logic          wr_half;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_done = 1'b0;
    logic          rd_bank_valid;
    logic          rd_half;
    logic [W-1:0]  rd_data;
    logic          rd_data_valid;
    logic          rd_err;

    ref_pingpong_bank #(
        .PIXEL       (PIXEL),
        .PIX_PER_WORD(PPW),
        .DEPTH       (DEPTH),
        .AW          (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .wr_half      (wr_half),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_done      (rd_done),
        .rd_bank_valid(rd_bank_valid),
        .rd_half      (rd_half),
        .rd_data      (rd_data),
        .rd_data_valid(rd_data_valid),
        .rd_err       (rd_err)
    );

    always #5 clk = ~clk;

    // Model: completed bands waiting for the reader, plus the band being loaded.
    typedef logic [W-1:0] band_t [DEPTH];
    band_t        bands[$];
    band_t        part;
    int           part_n;
    int           fills;
    int           rels;
    logic [W-1:0] exp_data;
    logic         exp_valid;
    logic         exp_err;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got,
                            input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit ready;
        bit avail;
        if (!rst_n) begin
            bands.delete();
            part_n    = 0;
            fills     = 0;
            rels      = 0;
            exp_data  = '0;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
        end else begin
            ready = (bands.size() < 2);
            avail = (bands.size() > 0);
            if (rd_en && avail && int'(rd_addr) < DEPTH) begin
                exp_data  = bands[0][rd_addr];
                exp_valid = 1'b1;
                exp_err   = 1'b0;
            end else begin
                exp_valid = 1'b0;
                exp_err   = rd_en;
            end
            if (rd_done && avail) begin
                void'(bands.pop_front());
                rels++;
            end
            if (wr_valid && ready) begin
                part[part_n] = wr_data;
                part_n++;
                if (part_n == DEPTH) begin
                    bands.push_back(part);
                    part_n = 0;
                    fills++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        check_eq("wr_ready", W'(wr_ready), W'(bands.size() < 2));
        check_eq("wr_half", W'(wr_half), W'(fills % 2));
        check_eq("rd_half", W'(rd_half), W'(rels % 2));
        check_eq("rd_bank_valid", W'(rd_bank_valid), W'(bands.size() > 0));
        check_eq("rd_data", rd_data, exp_data);
        check_eq("rd_data_valid", W'(rd_data_valid), W'(exp_valid));
        check_eq("rd_err", W'(rd_err), W'(exp_err));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic write_words(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = {8{8'(base + i)}};
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic read_word(input int addr);
        rd_en   = 1'b1;
        rd_addr = AW'(addr);
        tick();
        rd_en   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        do_reset();

        // Read with nothing full
        read_word(0);
        tick();

        // Fill half 0 and read it back, incl. last word and out-of-range
        write_words(DEPTH, 0);
        tick();
        rd_en = 1'b1;
        rd_addr = 7'd0;  tick();
        rd_addr = 7'd1;  tick();
        rd_addr = 7'd2;  tick();
        rd_addr = 7'd95; tick();
        rd_addr = 7'd96; tick();
        rd_en = 1'b0;
        tick();

        // Fill half 1, offer a word while both full, then release
        write_words(DEPTH, DEPTH);
        wr_valid = 1'b1;
        wr_data  = {8{8'hAA}};
        tick();
        wr_valid = 1'b0;
        rd_done  = 1'b1;
        tick();
        rd_done  = 1'b0;
        write_words(1, 8'h11);
        read_word(5);
        read_word(95);

        // Fill completion and release in the same cycle, with a read
        do_reset();
        write_words(DEPTH, 3);
        write_words(DEPTH - 1, 7);
        wr_valid = 1'b1;
        wr_data  = {8{8'h5A}};
        rd_done  = 1'b1;
        rd_en    = 1'b1;
        rd_addr  = 7'd3;
        tick();
        wr_valid = 1'b0;
        rd_done  = 1'b0;
        read_word(95);
        tick();

        // Reset mid-fill discards the partial band
        do_reset();
        write_words(40, 0);
        do_reset();
        write_words(DEPTH - 1, 50);
        tick();
        write_words(1, 9);
        read_word(0);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            rst_n    = ($urandom_range(0, 999) != 0);
            wr_valid = ($urandom_range(0, 9) < 7);
            wr_data  = {$urandom, $urandom};
            rd_en    = ($urandom_range(0, 1) == 1);
            rd_addr  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(96, 127))
                                                   : AW'($urandom_range(0, 95));
            rd_done  = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
